// File: rtl/spibone_pkg.sv
// Shared definitions for the SPI-to-bus bridge receiver: FSM states,
// response status codes and frame byte counts.
package spibone_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ISSUE,
        WAIT_RSP,
        RESP,
        DROP
    } state_t;

    localparam logic [7:0] STATUS_OK  = 8'h01;
    localparam logic [7:0] STATUS_ERR = 8'h02;

    localparam logic [2:0] ADDR_BYTES    = 3'd4;
    localparam logic [2:0] DATA_BYTES    = 3'd4;
    localparam logic [2:0] RESP_WR_BYTES = 3'd1;
    localparam logic [2:0] RESP_RD_BYTES = 3'd5;

endpackage

// File: rtl/spibone_sync_edge.sv
// Multi-stage synchroniser for asynchronous pins with rise/fall detection
// taken on the synchronised value.
module spibone_sync_edge #(
    parameter int               WIDTH     = 3,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage [STAGES];
    logic [WIDTH-1:0] prev;

    // Shift the raw pins through the chain and keep the previous output for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VAL;
            end
            prev <= RESET_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            prev <= stage[STAGES-1];
        end
    end

    assign q    = stage[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spibone_spi_rx.sv
// SPI mode-0 slave that decodes read/write frames into a single bus request
// and shifts the status (plus read data) back on MISO.
// Optional feature: define SPIBONE_CHECKSUM_EN to require a trailing XOR byte.
module spibone_spi_rx
    import spibone_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ    = 8'h01,
    parameter logic [7:0] CMD_WRITE   = 8'h02
) (
    input  logic        clk48,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [29:0] req_adr,
    output logic [31:0] req_dat,
    input  logic        rsp_valid,
    input  logic        rsp_err,
    input  logic [31:0] rsp_dat,
    output logic        frame_err
);

    logic [2:0] sync_q;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    // bit 0 = spi_clk, bit 1 = spi_mosi, bit 2 = spi_cs_n (idles high)
    spibone_sync_edge #(
        .WIDTH     (3),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (3'b100)
    ) u_sync (
        .clk   (clk48),
        .rst_n (reset_n),
        .din   ({spi_cs_n, spi_mosi, spi_clk}),
        .q     (sync_q),
        .rise  (sync_rise),
        .fall  (sync_fall)
    );

    logic mosi_s;
    logic cs_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic unused_sync;

    assign mosi_s      = sync_q[1];
    assign cs_s        = sync_q[2];
    assign sclk_rise   = sync_rise[0];
    assign sclk_fall   = sync_fall[0];
    assign cs_rise     = sync_rise[2];
    assign cs_fall     = sync_fall[2];
    assign unused_sync = ^{sync_q[0], sync_rise[1], sync_fall[1]};

    state_t      state;
    logic [6:0]  rx_sh;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [31:0] addr_sh;
    logic [31:0] data_sh;
    logic [39:0] tx_sh;
    logic        rsp_got;
    logic        discard;
    logic [7:0]  rx_byte;
    logic        byte_done;
`ifdef SPIBONE_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign req_adr   = addr_sh[31:2];
    assign req_dat   = data_sh;

    // Bit framing: sample MOSI on each rising edge, restart the byte at every cs_n fall.
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
        end else if (sclk_rise && state != IDLE && state != DROP) begin
            rx_sh   <= {rx_sh[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Frame FSM: decode command/address/data, run the bus handshake and shift the response.
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
            tx_sh     <= '0;
            rsp_got   <= 1'b0;
            discard   <= 1'b0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            spi_miso  <= 1'b0;
            frame_err <= 1'b0;
`ifdef SPIBONE_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            if (state != RESP) begin
                spi_miso <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= CMD;
                        byte_cnt <= '0;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (byte_done) begin
                        if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                            req_we   <= (rx_byte == CMD_WRITE);
                            state    <= ADDR;
                            byte_cnt <= '0;
`ifdef SPIBONE_CHECKSUM_EN
                            csum     <= rx_byte;
`endif
                        end else begin
                            state     <= DROP;
                            frame_err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (byte_done) begin
                        byte_cnt <= byte_cnt + 3'd1;
`ifdef SPIBONE_CHECKSUM_EN
                        if (byte_cnt == ADDR_BYTES) begin
                            if (rx_byte == csum) begin
                                state     <= ISSUE;
                                req_valid <= 1'b1;
                                rsp_got   <= 1'b0;
                                discard   <= 1'b0;
                            end else begin
                                state     <= DROP;
                                frame_err <= 1'b1;
                            end
                        end else begin
                            addr_sh <= {addr_sh[23:0], rx_byte};
                            csum    <= csum ^ rx_byte;
                            if (byte_cnt == ADDR_BYTES - 3'd1 && req_we) begin
                                state    <= DATA;
                                byte_cnt <= '0;
                            end
                        end
`else
                        addr_sh <= {addr_sh[23:0], rx_byte};
                        if (byte_cnt == ADDR_BYTES - 3'd1) begin
                            byte_cnt <= '0;
                            if (req_we) begin
                                state <= DATA;
                            end else begin
                                state     <= ISSUE;
                                req_valid <= 1'b1;
                                rsp_got   <= 1'b0;
                                discard   <= 1'b0;
                            end
                        end
`endif
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (byte_done) begin
                        byte_cnt <= byte_cnt + 3'd1;
`ifdef SPIBONE_CHECKSUM_EN
                        if (byte_cnt == DATA_BYTES) begin
                            if (rx_byte == csum) begin
                                state     <= ISSUE;
                                req_valid <= 1'b1;
                                rsp_got   <= 1'b0;
                                discard   <= 1'b0;
                            end else begin
                                state     <= DROP;
                                frame_err <= 1'b1;
                            end
                        end else begin
                            data_sh <= {data_sh[23:0], rx_byte};
                            csum    <= csum ^ rx_byte;
                        end
`else
                        data_sh <= {data_sh[23:0], rx_byte};
                        if (byte_cnt == DATA_BYTES - 3'd1) begin
                            byte_cnt  <= '0;
                            state     <= ISSUE;
                            req_valid <= 1'b1;
                            rsp_got   <= 1'b0;
                            discard   <= 1'b0;
                        end
`endif
                    end
                end
                ISSUE: begin
                    if (cs_rise) begin
                        discard <= 1'b1;
                    end
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (cs_rise) begin
                        discard <= 1'b1;
                    end
                    if (rsp_valid && !rsp_got) begin
                        rsp_got <= 1'b1;
                        tx_sh   <= {(rsp_err ? STATUS_ERR : STATUS_OK), rsp_dat};
                    end
                    if (discard && rsp_got) begin
                        state <= cs_s ? IDLE : DROP;
                    end else if (byte_done && rsp_got && !cs_rise) begin
                        state    <= RESP;
                        byte_cnt <= '0;
                    end
                end
                RESP: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end else begin
                        if (sclk_fall) begin
                            spi_miso <= tx_sh[39];
                            tx_sh    <= {tx_sh[38:0], 1'b0};
                        end
                        if (byte_done) begin
                            byte_cnt <= byte_cnt + 3'd1;
                            if (byte_cnt == (req_we ? RESP_WR_BYTES : RESP_RD_BYTES) - 3'd1) begin
                                state <= DROP;
                            end
                        end
                    end
                end
                DROP: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spibone_spi_rx.sv
// Self-checking bench for spibone_spi_rx: table vectors, hand sequences for
// abort/reset/late-cs cases, and randomized frames against a reference model.
`timescale 1ns/1ps
module tb_spibone_spi_rx;

    localparam int HALF = 6;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        err;
        int          readyDelay;
        int          rspDelay;
        int          csumFlip;
        int          expReq;
        int          expFerr;
        logic [29:0] expAdr;
        logic [31:0] expDat;
        logic [7:0]  expStatus;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk48 = 1'b0;
    logic        reset_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [29:0] req_adr;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    logic        frame_err;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          reqCount = 0;
    int          ferrCount = 0;
    int          stableBad = 0;
    int          readyDelay = 0;
    int          rspDelay = 0;
    logic        rspErrCfg = 1'b0;
    logic [31:0] rspDatCfg = '0;
    logic        lastWe = 1'b0;
    logic [29:0] lastAdr = '0;
    logic [31:0] lastDat = '0;

    spibone_spi_rx dut (
        .clk48     (clk48),
        .reset_n   (reset_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_dat   (rsp_dat),
        .frame_err (frame_err)
    );

    // 48 MHz-ish system clock
    always #10 clk48 = ~clk48;

    // Count frame_err pulses away from the active edge
    always @(negedge clk48) begin
        if (frame_err === 1'b1) ferrCount++;
    end

    // Bus bridge model: stalls req_ready, checks request stability, then answers
    initial begin : bridge
        logic        capWe;
        logic [29:0] capAdr;
        logic [31:0] capDat;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_dat   = '0;
        forever begin
            @(negedge clk48);
            if (req_valid === 1'b1) begin
                capWe  = req_we;
                capAdr = req_adr;
                capDat = req_dat;
                for (int i = 0; i < readyDelay; i++) begin
                    @(negedge clk48);
                    if (req_valid !== 1'b1 || req_we !== capWe || req_adr !== capAdr || req_dat !== capDat)
                        stableBad++;
                end
                req_ready = 1'b1;
                @(negedge clk48);
                req_ready = 1'b0;
                reqCount++;
                lastWe  = capWe;
                lastAdr = capAdr;
                lastDat = capDat;
                if (req_valid !== 1'b0) stableBad++;
                repeat (rspDelay) @(negedge clk48);
                rsp_valid = 1'b1;
                rsp_err   = rspErrCfg;
                rsp_dat   = rspDatCfg;
                @(negedge clk48);
                rsp_valid = 1'b0;
                rsp_err   = 1'b0;
                rsp_dat   = '0;
            end
        end
    end

    // Global watchdog so the run always ends
    initial begin : watchdog
        #4000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, testsRun=%0d", testsRun);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk48);
    endtask

    task automatic spiBegin();
        spi_cs_n = 1'b0;
        waitCyc(HALF);
    endtask

    task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            waitCyc(HALF);
            rx[i] = spi_miso;
            spi_clk = 1'b1;
            waitCyc(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spiEnd();
        waitCyc(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        waitCyc(HALF);
    endtask

    // Drive one whole frame as the SPI master and collect what comes back on MISO
    task automatic applyStimulus(input vec_t v, output logic [7:0] status, output logic [31:0] rdata,
                                 output logic [7:0] fillerOr, output logic gotStatus);
        logic [7:0] fb [16];
        logic [7:0] rb;
        logic [7:0] x;
        int n;
        readyDelay = v.readyDelay;
        rspDelay   = v.rspDelay;
        rspErrCfg  = v.err;
        rspDatCfg  = v.rdata;
        fb[0] = v.cmd;
        for (int i = 0; i < 4; i++) fb[1+i] = v.addr[31-8*i -: 8];
        n = 5;
        if (v.cmd != 8'h01) begin
            for (int i = 0; i < 4; i++) fb[5+i] = v.data[31-8*i -: 8];
            n = 9;
        end
`ifdef SPIBONE_CHECKSUM_EN
        x = '0;
        for (int i = 0; i < n; i++) x = x ^ fb[i];
        fb[n] = x ^ ((v.csumFlip != 0) ? 8'h01 : 8'h00);
        n++;
`else
        x = '0;
`endif
        status    = '0;
        rdata     = '0;
        fillerOr  = x & 8'h00;
        gotStatus = 1'b0;
        spiBegin();
        for (int i = 0; i < n; i++) begin
            spiByte(fb[i], rb);
            fillerOr = fillerOr | rb;
        end
        if (v.expReq != 0) begin
            for (int k = 0; k < 8 && !gotStatus; k++) begin
                spiByte(8'h00, rb);
                if (rb != 8'h00) begin
                    gotStatus = 1'b1;
                    status    = rb;
                end
            end
            if (gotStatus && v.cmd == 8'h01) begin
                for (int j = 0; j < 4; j++) begin
                    spiByte(8'h00, rb);
                    rdata = {rdata[23:0], rb};
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                spiByte(8'h5A, rb);
                fillerOr = fillerOr | rb;
            end
        end
        spiEnd();
        waitCyc(10);
    endtask

    // Apply one vector and compare everything observable with its expectations
    task automatic runVector(input vec_t v);
        int reqBefore;
        int ferrBefore;
        int badBefore;
        logic [7:0]  status;
        logic [31:0] rdata;
        logic [7:0]  fillerOr;
        logic        gotStatus;
        reqBefore  = reqCount;
        ferrBefore = ferrCount;
        badBefore  = stableBad;
        applyStimulus(v, status, rdata, fillerOr, gotStatus);
        checkOutput("req_count", 64'(reqCount - reqBefore), 64'(v.expReq));
        checkOutput("frame_err_count", 64'(ferrCount - ferrBefore), 64'(v.expFerr));
        checkOutput("miso_filler", 64'(fillerOr), 64'(0));
        checkOutput("req_stable", 64'(stableBad - badBefore), 64'(0));
        if (v.expReq != 0) begin
            checkOutput("resp_seen", 64'(gotStatus), 64'(1));
            checkOutput("req_we", 64'(lastWe), 64'(v.cmd == 8'h02));
            checkOutput("req_adr", 64'(lastAdr), 64'(v.expAdr));
            if (v.cmd == 8'h02) checkOutput("req_dat", 64'(lastDat), 64'(v.expDat));
            checkOutput("status", 64'(status), 64'(v.expStatus));
            if (v.cmd == 8'h01) checkOutput("rsp_data", 64'(rdata), 64'(v.expRdata));
        end
    endtask

    // Reference model: what the specification says a frame should produce
    function automatic vec_t refModel(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                                      input logic [31:0] rdata, input logic err, input int rd, input int sd);
        vec_t v;
        int   isValid;
        isValid      = (cmd == 8'h01 || cmd == 8'h02) ? 1 : 0;
        v.cmd        = cmd;
        v.addr       = addr;
        v.data       = data;
        v.rdata      = rdata;
        v.err        = err;
        v.readyDelay = rd;
        v.rspDelay   = sd;
        v.csumFlip   = 0;
        v.expReq     = isValid;
        v.expFerr    = 1 - isValid;
        v.expAdr     = 30'(addr / 32'd4);
        v.expDat     = data;
        v.expStatus  = err ? 8'h02 : 8'h01;
        v.expRdata   = rdata;
        return v;
    endfunction

    initial begin : main
        vec_t        vecs[$];
        vec_t        v;
        logic [7:0]  rb;
        logic [7:0]  cmd;
        int          reqBefore;
        int          ferrBefore;
        int          kind;

        vecs.push_back('{cmd:8'h02, addr:32'h00001004, data:32'hDEADBEEF, rdata:32'h0, err:1'b0,
                         readyDelay:0, rspDelay:5, csumFlip:0, expReq:1, expFerr:0,
                         expAdr:30'h401, expDat:32'hDEADBEEF, expStatus:8'h01, expRdata:32'h0});
        vecs.push_back('{cmd:8'h01, addr:32'h00000010, data:32'h0, rdata:32'h12345678, err:1'b0,
                         readyDelay:0, rspDelay:20, csumFlip:0, expReq:1, expFerr:0,
                         expAdr:30'h4, expDat:32'h0, expStatus:8'h01, expRdata:32'h12345678});
        vecs.push_back('{cmd:8'h7F, addr:32'h00000000, data:32'h0, rdata:32'h0, err:1'b0,
                         readyDelay:0, rspDelay:0, csumFlip:0, expReq:0, expFerr:1,
                         expAdr:30'h0, expDat:32'h0, expStatus:8'h00, expRdata:32'h0});
        vecs.push_back('{cmd:8'h01, addr:32'h80000013, data:32'h0, rdata:32'hCAFEF00D, err:1'b1,
                         readyDelay:3, rspDelay:10, csumFlip:0, expReq:1, expFerr:0,
                         expAdr:30'h20000004, expDat:32'h0, expStatus:8'h02, expRdata:32'hCAFEF00D});
        vecs.push_back('{cmd:8'h02, addr:32'hFFFFFFFF, data:32'h00000001, rdata:32'h0, err:1'b1,
                         readyDelay:1, rspDelay:0, csumFlip:0, expReq:1, expFerr:0,
                         expAdr:30'h3FFFFFFF, expDat:32'h00000001, expStatus:8'h02, expRdata:32'h0});
        vecs.push_back('{cmd:8'h02, addr:32'h00000100, data:32'h55AA55AA, rdata:32'h0, err:1'b0,
                         readyDelay:50, rspDelay:4, csumFlip:0, expReq:1, expFerr:0,
                         expAdr:30'h40, expDat:32'h55AA55AA, expStatus:8'h01, expRdata:32'h0});
        vecs.push_back('{cmd:8'h00, addr:32'h00000000, data:32'h0, rdata:32'h0, err:1'b0,
                         readyDelay:0, rspDelay:0, csumFlip:0, expReq:0, expFerr:1,
                         expAdr:30'h0, expDat:32'h0, expStatus:8'h00, expRdata:32'h0});
`ifdef SPIBONE_CHECKSUM_EN
        vecs.push_back('{cmd:8'h02, addr:32'h00001004, data:32'hDEADBEEF, rdata:32'h0, err:1'b0,
                         readyDelay:0, rspDelay:5, csumFlip:1, expReq:0, expFerr:1,
                         expAdr:30'h0, expDat:32'h0, expStatus:8'h00, expRdata:32'h0});
`endif

        reset_n  = 1'b0;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        waitCyc(3);
        checkOutput("reset_flags", 64'({req_valid, req_we, spi_miso, frame_err}), 64'(0));
        checkOutput("reset_req_adr", 64'(req_adr), 64'(0));
        checkOutput("reset_req_dat", 64'(req_dat), 64'(0));
        reset_n = 1'b1;
        waitCyc(5);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            runVector(vecs[i]);
        end

        // Abort after two address bytes
        reqBefore  = reqCount;
        ferrBefore = ferrCount;
        spiBegin();
        spiByte(8'h02, rb);
        spiByte(8'h00, rb);
        spiByte(8'h00, rb);
        spiEnd();
        waitCyc(20);
        checkOutput("abort_frame_err", 64'(ferrCount - ferrBefore), 64'(1));
        checkOutput("abort_no_req", 64'(reqCount - reqBefore), 64'(0));
        checkOutput("abort_req_valid", 64'(req_valid), 64'(0));
        runVector(vecs[0]);

        // Reset in the middle of the data phase
        reqBefore  = reqCount;
        ferrBefore = ferrCount;
        spiBegin();
        spiByte(8'h02, rb);
        spiByte(8'h12, rb);
        spiByte(8'h34, rb);
        spiByte(8'h56, rb);
        spiByte(8'h78, rb);
        spiByte(8'hAB, rb);
        spiByte(8'hCD, rb);
        reset_n = 1'b0;
        waitCyc(2);
        checkOutput("midrst_flags", 64'({req_valid, req_we, spi_miso, frame_err}), 64'(0));
        checkOutput("midrst_req_adr", 64'(req_adr), 64'(0));
        checkOutput("midrst_req_dat", 64'(req_dat), 64'(0));
        spi_cs_n = 1'b1;
        waitCyc(4);
        reset_n = 1'b1;
        waitCyc(20);
        checkOutput("midrst_no_frame_err", 64'(ferrCount - ferrBefore), 64'(0));
        checkOutput("midrst_no_req", 64'(reqCount - reqBefore), 64'(0));
        runVector(vecs[1]);

        // cs_n rises while the request is still outstanding
        reqBefore  = reqCount;
        ferrBefore = ferrCount;
        readyDelay = 5;
        rspDelay   = 60;
        rspErrCfg  = 1'b0;
        rspDatCfg  = 32'hA5A5A5A5;
        spiBegin();
        spiByte(8'h01, rb);
        spiByte(8'h00, rb);
        spiByte(8'h00, rb);
        spiByte(8'h00, rb);
        spiByte(8'h20, rb);
        spiEnd();
        waitCyc(150);
        checkOutput("latecs_req_done", 64'(reqCount - reqBefore), 64'(1));
        checkOutput("latecs_req_adr", 64'(lastAdr), 64'(30'h8));
        checkOutput("latecs_no_frame_err", 64'(ferrCount - ferrBefore), 64'(0));
        checkOutput("latecs_req_valid", 64'(req_valid), 64'(0));
        runVector(vecs[1]);

        // Randomized frames against the reference model
        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)      cmd = 8'h01;
            else if (kind < 8) cmd = 8'h02;
            else               cmd = 8'($urandom);
            v = refModel(cmd, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 12), $urandom_range(0, 40));
            runVector(v);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
